// File: rtl/axi_arbiter.sv
// Two-master AXI4-style arbiter in front of a single 64-bit word RAM.
// Master 1 (fetch) only reads; master 2 (load/store) reads and writes.
// Only one transaction is in flight at a time, and every transaction
// returns through IDLE before the next one is granted.
module axi_arbiter #(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          DEPTH = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr_1,
  input  logic        arvalid_1,
  input  logic [1:0]  arburst_1,
  input  logic [7:0]  arlen_1,
  input  logic [2:0]  arsize_1,
  output logic        arready_1,
  output logic [63:0] rdata_1,
  output logic [1:0]  rresp_1,
  output logic        rvalid_1,
  output logic        rlast_1,
  input  logic        rready_1,
  input  logic [31:0] araddr_2,
  input  logic        arvalid_2,
  input  logic [1:0]  arburst_2,
  input  logic [7:0]  arlen_2,
  input  logic [2:0]  arsize_2,
  output logic        arready_2,
  output logic [63:0] rdata_2,
  output logic [1:0]  rresp_2,
  output logic        rvalid_2,
  output logic        rlast_2,
  input  logic        rready_2,
  input  logic [31:0] awaddr_2,
  input  logic        awvalid_2,
  input  logic [1:0]  awburst_2,
  input  logic [7:0]  awlen_2,
  output logic        awready_2,
  input  logic [63:0] wdata_2,
  input  logic [7:0]  wstrb_2,
  input  logic        wlast_2,
  input  logic        wvalid_2,
  output logic        wready_2,
  output logic [1:0]  bresp_2,
  output logic        bvalid_2,
  input  logic        bready_2,
  input  logic        inst_update,
  input  logic        mem_finish
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR, WRESP} state_t;

  state_t      state_q;
  logic [31:0] addr_q;    // current beat address
  logic [7:0]  cnt_q;     // read beats remaining minus 1
  logic        fixed_q;   // FIXED burst: address does not advance
  logic        err_q;     // some write beat of this burst missed the RAM

  logic [63:0] mem [DEPTH];

  logic [31:0]   off;
  logic          in_rng;
  logic [AW-1:0] idx;
  logic [63:0]   rword;
  logic [31:0]   addr_nxt;
  logic          g_r1, g_r2, g_w2;
  logic          w_hs;

  // Word decode of the current address; low three bits never matter.
  assign off      = addr_q - BASE;
  assign in_rng   = (addr_q >= BASE) && ({3'b000, off[31:3]} < 32'(DEPTH));
  assign idx      = off[AW+2:3];
  assign rword    = in_rng ? mem[idx] : 64'd0;
  assign addr_nxt = fixed_q ? addr_q : addr_q + 32'd8;

  // Fixed-priority grant, only evaluated in IDLE; mem_finish lets fetch jump the queue.
  always_comb begin
    g_r1 = 1'b0;
    g_r2 = 1'b0;
    g_w2 = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (mem_finish) begin
        if (arvalid_1)      g_r1 = 1'b1;
        else if (awvalid_2) g_w2 = 1'b1;
        else if (arvalid_2) g_r2 = 1'b1;
      end else begin
        if (awvalid_2)      g_w2 = 1'b1;
        else if (arvalid_2) g_r2 = 1'b1;
        else if (arvalid_1) g_r1 = 1'b1;
      end
    end
  end

  assign arready_1 = g_r1;
  assign arready_2 = g_r2;
  assign awready_2 = g_w2;

  assign rvalid_1 = (state_q == RD1);
  assign rlast_1  = (state_q == RD1) && (cnt_q == 8'd0);
  assign rdata_1  = (state_q == RD1) ? rword : 64'd0;
  assign rresp_1  = ((state_q == RD1) && !in_rng) ? 2'b10 : 2'b00;

  assign rvalid_2 = (state_q == RD2);
  assign rlast_2  = (state_q == RD2) && (cnt_q == 8'd0);
  assign rdata_2  = (state_q == RD2) ? rword : 64'd0;
  assign rresp_2  = ((state_q == RD2) && !in_rng) ? 2'b10 : 2'b00;

  // wready is masked by reset so no RAM write can slip in while resetting.
  assign wready_2 = (state_q == WR) && !rst;
  assign w_hs     = wready_2 && wvalid_2;
  assign bvalid_2 = (state_q == WRESP);
  assign bresp_2  = ((state_q == WRESP) && err_q) ? 2'b10 : 2'b00;

  // Transaction sequencer: grant, beat stepping and write response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      fixed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (g_r1) begin
            addr_q  <= araddr_1;
            cnt_q   <= arlen_1;
            fixed_q <= (arburst_1 == 2'b00);
            state_q <= RD1;
          end else if (g_r2) begin
            addr_q  <= araddr_2;
            cnt_q   <= arlen_2;
            fixed_q <= (arburst_2 == 2'b00);
            state_q <= RD2;
          end else if (g_w2) begin
            addr_q  <= awaddr_2;
            fixed_q <= (awburst_2 == 2'b00);
            err_q   <= 1'b0;
            state_q <= WR;
          end
        end
        RD1: if (rready_1) begin
          addr_q <= addr_nxt;
          cnt_q  <= cnt_q - 8'd1;
          if (cnt_q == 8'd0) state_q <= IDLE;
        end
        RD2: if (rready_2) begin
          addr_q <= addr_nxt;
          cnt_q  <= cnt_q - 8'd1;
          if (cnt_q == 8'd0) state_q <= IDLE;
        end
        WR: if (wvalid_2) begin
          // wlast alone ends the burst; awlen is not trusted
          addr_q <= addr_nxt;
          if (!in_rng) err_q <= 1'b1;
          if (wlast_2) state_q <= WRESP;
        end
        WRESP: if (bready_2) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte-masked RAM write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_hs && in_rng) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb_2[b]) mem[idx][8*b +: 8] <= wdata_2[8*b +: 8];
      end
    end
  end

  // Inputs the bus accepts but has no use for.
  logic unused_ok;
  assign unused_ok = ^{arsize_1, arsize_2, awlen_2, inst_update, off[2:0], off[31:AW+3]};

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed + randomized bench for axi_arbiter against a word-array memory model.
module tb_axi_arbiter;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr_1, araddr_2, awaddr_2;
  logic        arvalid_1, arvalid_2, awvalid_2;
  logic [1:0]  arburst_1, arburst_2, awburst_2;
  logic [7:0]  arlen_1, arlen_2, awlen_2;
  logic [2:0]  arsize_1, arsize_2;
  logic        arready_1, arready_2, awready_2;
  logic [63:0] rdata_1, rdata_2, wdata_2;
  logic [1:0]  rresp_1, rresp_2, bresp_2;
  logic        rvalid_1, rvalid_2, rlast_1, rlast_2, rready_1, rready_2;
  logic [7:0]  wstrb_2;
  logic        wlast_2, wvalid_2, wready_2, bvalid_2, bready_2;
  logic        inst_update, mem_finish;

  int checks = 0;
  int errors = 0;
  logic [63:0] rm [DEPTH];

  axi_arbiter #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .araddr_1(araddr_1), .arvalid_1(arvalid_1), .arburst_1(arburst_1), .arlen_1(arlen_1),
    .arsize_1(arsize_1), .arready_1(arready_1), .rdata_1(rdata_1), .rresp_1(rresp_1),
    .rvalid_1(rvalid_1), .rlast_1(rlast_1), .rready_1(rready_1),
    .araddr_2(araddr_2), .arvalid_2(arvalid_2), .arburst_2(arburst_2), .arlen_2(arlen_2),
    .arsize_2(arsize_2), .arready_2(arready_2), .rdata_2(rdata_2), .rresp_2(rresp_2),
    .rvalid_2(rvalid_2), .rlast_2(rlast_2), .rready_2(rready_2),
    .awaddr_2(awaddr_2), .awvalid_2(awvalid_2), .awburst_2(awburst_2), .awlen_2(awlen_2),
    .awready_2(awready_2), .wdata_2(wdata_2), .wstrb_2(wstrb_2), .wlast_2(wlast_2),
    .wvalid_2(wvalid_2), .wready_2(wready_2), .bresp_2(bresp_2), .bvalid_2(bvalid_2),
    .bready_2(bready_2), .inst_update(inst_update), .mem_finish(mem_finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_inr(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 3) < 32'(DEPTH));
  endfunction

  function automatic logic [63:0] model_rd(input logic [31:0] a);
    if (model_inr(a)) return rm[int'((a - BASE) >> 3)];
    return 64'd0;
  endfunction

  // One read transaction on master m; rready follows pat (LSB first) or is random.
  task automatic rd(input int m, input logic [31:0] a, input logic [7:0] len,
                    input logic [1:0] burst, input logic [31:0] pat, input bit use_pat);
    int beat;
    int cyc;
    logic [31:0] cur;
    logic rr, rv, rl, ov;
    logic [63:0] rdv;
    logic [1:0] rs;
    beat = 0; cyc = 0; cur = a;
    @(negedge clk);
    if (m == 1) begin araddr_1 = a; arlen_1 = len; arburst_1 = burst; arvalid_1 = 1'b1; end
    else        begin araddr_2 = a; arlen_2 = len; arburst_2 = burst; arvalid_2 = 1'b1; end
    #1 chk("arready", (m == 1) ? arready_1 : arready_2, 1);
    @(negedge clk);
    arvalid_1 = 1'b0; arvalid_2 = 1'b0;
    while (beat <= int'(len) && cyc < 300) begin
      rr = use_pat ? ((cyc < 32) ? pat[cyc] : 1'b1) : ($urandom_range(0, 3) != 0);
      if (m == 1) rready_1 = rr; else rready_2 = rr;
      #1;
      rv  = (m == 1) ? rvalid_1 : rvalid_2;
      rl  = (m == 1) ? rlast_1  : rlast_2;
      rdv = (m == 1) ? rdata_1  : rdata_2;
      rs  = (m == 1) ? rresp_1  : rresp_2;
      ov  = (m == 1) ? rvalid_2 : rvalid_1;
      chk("rvalid", rv, 1);
      chk("rdata", rdv, model_rd(cur));
      chk("rresp", rs, model_inr(cur) ? 2'b00 : 2'b10);
      chk("rlast", rl, beat == int'(len));
      chk("other_rvalid", ov, 0);
      if (rr) begin
        beat++;
        if (burst != 2'b00) cur += 32'd8;
      end
      cyc++;
      @(negedge clk);
    end
    rready_1 = 1'b0; rready_2 = 1'b0;
    chk("rd_done", beat, int'(len) + 1);
    #1 chk("rvalid_idle", (m == 1) ? rvalid_1 : rvalid_2, 0);
  endtask

  // One write burst of n beats on master 2; given data/strobe or random.
  task automatic wr(input logic [31:0] a, input int n, input logic [1:0] burst,
                    input bit given, input logic [63:0] d0, input logic [7:0] s0, input bit full);
    logic [31:0] cur;
    logic [63:0] d;
    logic [7:0] s;
    bit err;
    int wi;
    cur = a; err = 0;
    @(negedge clk);
    awaddr_2 = a; awburst_2 = burst; awlen_2 = 8'(n - 1); awvalid_2 = 1'b1;
    #1 chk("awready", awready_2, 1);
    @(negedge clk);
    awvalid_2 = 1'b0;
    for (int k = 0; k < n; k++) begin
      d = given ? d0 : {$urandom, $urandom};
      s = given ? s0 : (full ? 8'hFF : 8'($urandom));
      wdata_2 = d; wstrb_2 = s; wlast_2 = (k == n - 1); wvalid_2 = 1'b1;
      #1 chk("wready", wready_2, 1);
      chk("bvalid_early", bvalid_2, 0);
      if (model_inr(cur)) begin
        wi = int'((cur - BASE) >> 3);
        for (int b = 0; b < 8; b++) if (s[b]) rm[wi][8*b +: 8] = d[8*b +: 8];
      end else err = 1;
      if (burst != 2'b00) cur += 32'd8;
      @(negedge clk);
    end
    wvalid_2 = 1'b0; wlast_2 = 1'b0; bready_2 = 1'b1;
    #1 chk("bvalid", bvalid_2, 1);
    chk("bresp", bresp_2, err ? 2'b10 : 2'b00);
    @(negedge clk);
    bready_2 = 1'b0;
    #1 chk("bvalid_idle", bvalid_2, 0);
  endtask

  initial begin
    rst = 1'b1;
    araddr_1 = '0; araddr_2 = '0; awaddr_2 = '0;
    arvalid_1 = 0; arvalid_2 = 0; awvalid_2 = 0;
    arburst_1 = 2'b01; arburst_2 = 2'b01; awburst_2 = 2'b01;
    arlen_1 = '0; arlen_2 = '0; awlen_2 = '0; arsize_1 = 3'd3; arsize_2 = 3'd3;
    rready_1 = 0; rready_2 = 0; wdata_2 = '0; wstrb_2 = '0; wlast_2 = 0; wvalid_2 = 0;
    bready_2 = 0; inst_update = 0; mem_finish = 0;
    for (int i = 0; i < DEPTH; i++) rm[i] = 'x;

    // reset state
    repeat (3) @(negedge clk);
    #1 chk("rst_ready", {arready_1, arready_2, awready_2, wready_2}, 0);
    chk("rst_status", {rvalid_1, rlast_1, rresp_1, rvalid_2, rlast_2, rresp_2, bvalid_2, bresp_2}, 0);
    chk("rst_rdata1", rdata_1, 0);
    chk("rst_rdata2", rdata_2, 0);
    @(negedge clk);
    rst = 1'b0;

    // fill words 0..31, then place the known test words
    wr(BASE, 32, 2'b01, 0, 64'd0, 8'h00, 1);
    wr(BASE, 1, 2'b01, 1, 64'h1122_3344_5566_7788, 8'hFF, 0);
    wr(BASE + 32'd8, 1, 2'b01, 1, 64'd0, 8'hFF, 0);

    // master-1 single read of word 0
    rd(1, BASE, 8'd0, 2'b01, 32'hFFFF_FFFF, 1);

    // partial-strobe write then read back
    wr(BASE + 32'd8, 1, 2'b01, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0);
    chk("partial_model", model_rd(BASE + 32'd8), 64'h0000_0000_FFFF_FFFF);
    rd(2, BASE + 32'd8, 8'd0, 2'b01, 32'hFFFF_FFFF, 1);

    // both reads valid, mem_finish=0: master 2 first, master 1 waits
    @(negedge clk);
    araddr_1 = BASE + 32'd16; arlen_1 = 0; arburst_1 = 2'b01; arvalid_1 = 1;
    araddr_2 = BASE + 32'd24; arlen_2 = 0; arburst_2 = 2'b01; arvalid_2 = 1;
    #1 chk("arb0_ar2", arready_2, 1);
    chk("arb0_ar1", arready_1, 0);
    @(negedge clk);
    arvalid_2 = 0; rready_2 = 1;
    #1 chk("arb0_rv2", rvalid_2, 1);
    chk("arb0_rd2", rdata_2, model_rd(BASE + 32'd24));
    chk("arb0_rl2", rlast_2, 1);
    chk("arb0_ar1_wait", arready_1, 0);
    @(negedge clk);
    rready_2 = 0;
    #1 chk("arb0_ar1_go", arready_1, 1);
    @(negedge clk);
    arvalid_1 = 0; rready_1 = 1;
    #1 chk("arb0_rv1", rvalid_1, 1);
    chk("arb0_rd1", rdata_1, model_rd(BASE + 32'd16));
    chk("arb0_rl1", rlast_1, 1);
    @(negedge clk);
    rready_1 = 0;
    // write beats read-2 with mem_finish=0 (requests withdrawn before the edge)
    arvalid_2 = 1; awvalid_2 = 1;
    #1 chk("arb0_aw", awready_2, 1);
    chk("arb0_ar2_lose", arready_2, 0);
    arvalid_2 = 0; awvalid_2 = 0;

    // mem_finish=1: fetch read beats everything
    @(negedge clk);
    mem_finish = 1; inst_update = 1;
    araddr_1 = BASE + 32'd32; arlen_1 = 0; arvalid_1 = 1;
    arvalid_2 = 1; awvalid_2 = 1;
    #1 chk("arb1_ar1", arready_1, 1);
    chk("arb1_aw", awready_2, 0);
    chk("arb1_ar2", arready_2, 0);
    @(negedge clk);
    arvalid_1 = 0; rready_1 = 1;
    #1 chk("arb1_rd1", rdata_1, model_rd(BASE + 32'd32));
    chk("arb1_ready_busy", {arready_2, awready_2}, 0);
    @(negedge clk);
    rready_1 = 0;
    #1 chk("arb1_aw_next", awready_2, 1);
    chk("arb1_ar2_next", arready_2, 0);
    arvalid_2 = 0; awvalid_2 = 0; mem_finish = 0; inst_update = 0;

    // 4-beat INCR read with rready 1,0,1,1,1
    rd(2, BASE, 8'd3, 2'b01, 32'h0000_001D, 1);

    // out-of-range reads below BASE and past the end
    rd(2, 32'h7FFF_FFF8, 8'd0, 2'b01, 32'hFFFF_FFFF, 1);
    rd(1, BASE + 32'(DEPTH * 8) - 32'd8, 8'd1, 2'b01, 32'hFFFF_FFFF, 1);

    // FIXED read burst and WRAP treated as INCR
    rd(1, BASE + 32'd16, 8'd2, 2'b00, 32'd0, 0);
    rd(2, BASE + 32'd40, 8'd2, 2'b10, 32'd0, 0);

    // write straddling the top of RAM: last word written, bresp error
    wr(BASE + 32'(DEPTH * 8) - 32'd8, 2, 2'b01, 0, 64'd0, 8'h00, 1);
    rd(2, BASE + 32'(DEPTH * 8) - 32'd8, 8'd1, 2'b01, 32'd0, 0);

    // FIXED write: every beat lands on the same word
    wr(BASE + 32'd24, 3, 2'b00, 0, 64'd0, 8'h00, 0);
    rd(1, BASE + 32'd24, 8'd0, 2'b01, 32'd0, 0);

    // randomized mix within words 0..31
    for (int it = 0; it < 24; it++) begin
      logic [31:0] ra;
      logic [1:0] bt;
      logic [7:0] ln;
      ra = BASE + 32'($urandom_range(0, 28)) * 32'd8 + 32'($urandom_range(0, 7));
      bt = 2'($urandom_range(0, 2));
      ln = 8'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: rd(1, ra, ln, bt, 32'd0, 0);
        1: rd(2, ra, ln, bt, 32'd0, 0);
        default: wr(ra, int'(ln) + 1, bt, 0, 64'd0, 8'h00, 0);
      endcase
    end

    // reset during beat 2 of a burst
    @(negedge clk);
    araddr_2 = BASE; arlen_2 = 3; arburst_2 = 2'b01; arvalid_2 = 1;
    #1 chk("rstb_ar", arready_2, 1);
    @(negedge clk);
    arvalid_2 = 0; rready_2 = 1;
    #1 chk("rstb_beat1", rdata_2, model_rd(BASE));
    @(negedge clk);
    #1 chk("rstb_beat2", rdata_2, model_rd(BASE + 32'd8));
    rst = 1;
    @(negedge clk);
    rst = 0; rready_2 = 0;
    #1 chk("rstb_rvalid", {rvalid_2, rlast_2, rresp_2, rvalid_1}, 0);
    chk("rstb_rdata", rdata_2, 0);
    chk("rstb_bvalid", {bvalid_2, wready_2}, 0);
    rd(1, BASE + 32'd8, 8'd1, 2'b01, 32'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
